// File: rtl/dcache_wb_ctrl.sv
// Direct-mapped write-back/write-allocate data cache controller between the LSU and the DRAM model.
// Latency: hit 1 cycle after acceptance, clean miss 4, dirty miss 5 (plus any DRAM stall cycles).
// Backpressure: one request in flight (cpu_busy); DRAM stalls by holding mem_ready low while mem_req is high.
// Optional: define DCACHE_STATS_EN to add saturating o_hit_count/o_miss_count outputs.
module dcache_wb_ctrl #(
  parameter int DATA_W = 11,
  parameter int LINES  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_cpu_req,
  input  logic              i_cpu_we,
  input  logic [31:0]       i_cpu_addr,
  input  logic [DATA_W-1:0] i_cpu_wdata,
  output logic              o_cpu_busy,
  output logic              o_cpu_ready,
  output logic [DATA_W-1:0] o_cpu_rdata,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [31:0]       o_mem_address,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic              i_mem_ready,
  input  logic [DATA_W-1:0] i_mem_rdata
`ifdef DCACHE_STATS_EN
  ,
  output logic [15:0]       o_hit_count,
  output logic [15:0]       o_miss_count
`endif
);

  localparam int IDX   = $clog2(LINES);
  localparam int TAG_W = 10 - IDX;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_WB,
    S_FILL,
    S_FILL_WAIT
  } state_t;

  state_t            r_state;
  logic              r_we;
  logic [9:0]        r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [LINES-1:0]  r_valid;
  logic [LINES-1:0]  r_dirty;
  logic [TAG_W-1:0]  r_tag  [LINES];
  logic [DATA_W-1:0] r_data [LINES];
  logic              r_cpu_ready;
  logic [DATA_W-1:0] r_cpu_rdata;

  logic [IDX-1:0]    w_idx;
  logic [TAG_W-1:0]  w_tag;
  logic              w_hit;
  logic              w_victim_dirty;
  logic              w_unused;

  // Upper address bits alias onto the same 1024-word space and are dropped.
  assign w_unused       = ^i_cpu_addr[31:10];

  assign w_idx          = r_addr[IDX-1:0];
  assign w_tag          = r_addr[9:IDX];
  assign w_hit          = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_victim_dirty = r_valid[w_idx] && r_dirty[w_idx];

  assign o_cpu_busy  = (r_state != S_IDLE);
  assign o_cpu_ready = r_cpu_ready;
  assign o_cpu_rdata = r_cpu_rdata;

  // DRAM port is a pure decode of the state and the latched request; idle fields stay zero.
  always_comb begin
    o_mem_req     = 1'b0;
    o_mem_we      = 1'b0;
    o_mem_address = 32'd0;
    o_mem_wdata   = '0;
    case (r_state)
      S_WB: begin
        o_mem_req     = 1'b1;
        o_mem_we      = 1'b1;
        o_mem_address = {22'd0, r_tag[w_idx], w_idx};
        o_mem_wdata   = r_data[w_idx];
      end
      S_FILL: begin
        o_mem_req     = 1'b1;
        o_mem_address = {22'd0, r_addr};
      end
      default: ;
    endcase
  end

  // Control FSM: request latch, line valid/dirty bits and the registered CPU response.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_valid     <= '0;
      r_dirty     <= '0;
      r_cpu_ready <= 1'b0;
      r_cpu_rdata <= '0;
    end else begin
      r_cpu_ready <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_cpu_req) begin
            r_we    <= i_cpu_we;
            r_addr  <= i_cpu_addr[9:0];
            r_wdata <= i_cpu_wdata;
            r_state <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (w_hit) begin
            if (r_we) begin
              r_dirty[w_idx] <= 1'b1;
            end else begin
              r_cpu_rdata <= r_data[w_idx];
            end
            r_cpu_ready <= 1'b1;
            r_state     <= S_IDLE;
          end else if (w_victim_dirty) begin
            r_state <= S_WB;
          end else begin
            r_state <= S_FILL;
          end
        end
        S_WB: begin
          if (i_mem_ready) begin
            r_dirty[w_idx] <= 1'b0;
            r_state        <= S_FILL;
          end
        end
        S_FILL: begin
          if (i_mem_ready) begin
            r_state <= S_FILL_WAIT;
          end
        end
        S_FILL_WAIT: begin
          // Replay the lookup so a pending store merges into the freshly filled line.
          r_valid[w_idx] <= 1'b1;
          r_dirty[w_idx] <= 1'b0;
          r_state        <= S_LOOKUP;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Tag/data storage needs no reset: the valid bits gate every use of it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (r_state == S_LOOKUP && w_hit && r_we) begin
        r_data[w_idx] <= r_wdata;
      end else if (r_state == S_FILL_WAIT) begin
        r_data[w_idx] <= i_mem_rdata;
        r_tag[w_idx]  <= w_tag;
      end
    end
  end

`ifdef DCACHE_STATS_EN
  logic        r_first;
  logic [15:0] r_hit_count;
  logic [15:0] r_miss_count;

  assign o_hit_count  = r_hit_count;
  assign o_miss_count = r_miss_count;

  // Count only the first lookup of each request; replays after a fill are ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_first      <= 1'b0;
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else begin
      if (r_state == S_IDLE && i_cpu_req) begin
        r_first <= 1'b1;
      end else if (r_state == S_LOOKUP) begin
        r_first <= 1'b0;
        if (r_first) begin
          if (w_hit) begin
            if (r_hit_count != 16'hFFFF) r_hit_count <= r_hit_count + 16'd1;
          end else begin
            if (r_miss_count != 16'hFFFF) r_miss_count <= r_miss_count + 16'd1;
          end
        end
      end
    end
  end
`endif

endmodule
